// File: rtl/spike_rate_decoder_if.sv
// Bundles the spike input, control and rate valid/ready result signals of spike_rate_decoder.
// SPIKE_DECODER_ISI_EN adds the inter-spike-interval output.
interface spike_rate_decoder_if #(
    parameter int CNT_W = 8
);
    logic             spike;
    logic             enable;
    logic [7:0]       window_len;
    logic [CNT_W-1:0] rate;
    logic             rate_valid;
    logic             rate_ready;
    logic             dropped;
    logic             busy;
`ifdef SPIKE_DECODER_ISI_EN
    logic [CNT_W-1:0] isi;

    modport master (
        output spike, enable, window_len, rate_ready,
        input  rate, rate_valid, dropped, busy, isi
    );
    modport slave (
        input  spike, enable, window_len, rate_ready,
        output rate, rate_valid, dropped, busy, isi
    );
`else
    modport master (
        output spike, enable, window_len, rate_ready,
        input  rate, rate_valid, dropped, busy
    );
    modport slave (
        input  spike, enable, window_len, rate_ready,
        output rate, rate_valid, dropped, busy
    );
`endif
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a programmable window and presents the count on a valid/ready output.
// Optional macro SPIKE_DECODER_ISI_EN adds an inter-spike-interval measurement on bus.isi.
module spike_rate_decoder #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_WIN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spike_rate_decoder_if.slave  bus
);
    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state_q, state_d;
    logic [8:0]       len_q, len_d;
    logic [7:0]       cyc_q, cyc_d;
    logic [CNT_W-1:0] spk_q, spk_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             vld_q, vld_d;
    logic             drop_q, drop_d;

    logic [8:0]       new_len;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] result;
    logic             win_end;
    logic             load;

    assign new_len = (bus.window_len == 8'd0) ? 9'd256 : {1'b0, bus.window_len};
    // The final cycle's spike is folded into the result rather than the counter.
    assign sum     = {1'b0, spk_q} + {{CNT_W{1'b0}}, bus.spike};
    assign result  = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    assign win_end = (state_q == COUNT) && ({1'b0, cyc_q} == len_q - 9'd1);
    assign load    = win_end && (!vld_q || bus.rate_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= 9'(DEFAULT_WIN);
            cyc_q   <= '0;
            spk_q   <= '0;
            rate_q  <= '0;
            vld_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
            spk_q   <= spk_d;
            rate_q  <= rate_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cyc_d   = cyc_q;
        spk_d   = spk_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = COUNT;
                    len_d   = new_len;
                    cyc_d   = '0;
                    spk_d   = '0;
                end
            end
            COUNT: begin
                if (win_end) begin
                    cyc_d = '0;
                    spk_d = '0;
                    if (bus.enable) len_d   = new_len;
                    else            state_d = IDLE;
                end else if (!bus.enable) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    spk_d   = '0;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                    spk_d = spk_q + {{(CNT_W-1){1'b0}}, bus.spike};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output buffer: a single slot, refilled in the same cycle it is consumed.
    always_comb begin
        rate_d = rate_q;
        vld_d  = vld_q;
        drop_d = drop_q;
        if (vld_q && bus.rate_ready) vld_d = 1'b0;
        if (load) begin
            rate_d = result;
            vld_d  = 1'b1;
        end
        if (win_end && !load) drop_d = 1'b1;
    end

    assign bus.rate       = rate_q;
    assign bus.rate_valid = vld_q;
    assign bus.dropped    = drop_q;
    assign bus.busy       = (state_q == COUNT);

`ifdef SPIKE_DECODER_ISI_EN
    logic [CNT_W-1:0] isi_q, gap_q;
    logic             seen_q;

    // gap_q counts cycles since the last spike; it keeps running across windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isi_q  <= '0;
            gap_q  <= '0;
            seen_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.enable) begin
                isi_q  <= '0;
                gap_q  <= '0;
                seen_q <= 1'b0;
            end
        end else if (bus.spike) begin
            isi_q  <= seen_q ? gap_q : '0;
            gap_q  <= {{(CNT_W-1){1'b0}}, 1'b1};
            seen_q <= 1'b1;
        end else if (gap_q != {CNT_W{1'b1}}) begin
            gap_q <= gap_q + 1'b1;
        end
    end

    assign bus.isi = isi_q;
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: table-driven windows plus hand sequences, with a
// scoreboard queue of expected rates popped on every accepted handshake.
module tb_spike_rate_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   q[$];

    always #5 clk = ~clk;

    spike_rate_decoder_if #(.CNT_W(8)) ifc ();

    spike_rate_decoder #(.CNT_W(8), .DEFAULT_WIN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [7:0]  wlen;
        logic [31:0] pat;
        int          exp_rate;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted result must match the oldest expected rate.
    always @(negedge clk) begin
        if (rst_n && ifc.rate_valid && ifc.rate_ready) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else               chk("rate", int'(ifc.rate), q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.spike = 1'b0;
        ifc.enable = 1'b0;
        ifc.window_len = 8'd0;
        ifc.rate_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{8'd8,  32'b0010_0101, 3};
        vecs[1] = '{8'd4,  32'hF,         4};
        vecs[2] = '{8'd1,  32'h1,         1};
        vecs[3] = '{8'd1,  32'h0,         0};
        vecs[4] = '{8'd32, 32'hAAAA_AAAA, 16};
        vecs[5] = '{8'd5,  32'h0,         0};
        vecs[6] = '{8'd20, 32'h000F_FFFF, 20};
        vecs[7] = '{8'd3,  32'b101,       2};

        do_reset();
        chk("reset_rate", int'(ifc.rate), 0);
        chk("reset_valid", int'(ifc.rate_valid), 0);
        chk("reset_dropped", int'(ifc.dropped), 0);
        chk("reset_busy", int'(ifc.busy), 0);

        // Table: single windows ending with enable low on the final cycle
        ifc.rate_ready = 1'b1;
        foreach (vecs[i]) begin
            int n;
            n = int'(vecs[i].wlen);
            ifc.window_len = vecs[i].wlen;
            ifc.enable = 1'b1;
            ifc.spike = 1'b0;
            q.push_back(vecs[i].exp_rate);
            step();
            for (int k = 0; k < n; k++) begin
                ifc.spike = vecs[i].pat[k];
                ifc.enable = (k != n - 1);
                if (k == n - 1) chk("valid_before_end", int'(ifc.rate_valid), 0);
                step();
            end
            ifc.spike = 1'b0;
            chk("valid_latency", int'(ifc.rate_valid), 1);
            wait_drain();
            step();
            chk("valid_pulse", int'(ifc.rate_valid), 0);
            chk("idle_busy", int'(ifc.busy), 0);
        end

        // 256-cycle window with a spike every cycle saturates at 255
        ifc.window_len = 8'd0;
        ifc.enable = 1'b1;
        ifc.spike = 1'b1;
        q.push_back(255);
        step();
        for (int k = 0; k < 256; k++) begin
            chk("busy_256", int'(ifc.busy), 1);
            ifc.enable = (k != 255);
            step();
        end
        ifc.spike = 1'b0;
        chk("valid_256", int'(ifc.rate_valid), 1);
        wait_drain();
        step();

        // Back-pressure: second result dropped, first held
        do_reset();
        ifc.window_len = 8'd4;
        ifc.enable = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] p;
            p = 8'b0001_0011;
            ifc.spike = p[k];
            ifc.enable = (k != 7);
            step();
        end
        ifc.spike = 1'b0;
        chk("bp_valid", int'(ifc.rate_valid), 1);
        chk("bp_rate", int'(ifc.rate), 2);
        chk("bp_dropped", int'(ifc.dropped), 1);
        q.push_back(2);
        ifc.rate_ready = 1'b1;
        wait_drain();
        step();
        chk("bp_valid_clear", int'(ifc.rate_valid), 0);
        chk("bp_dropped_sticky", int'(ifc.dropped), 1);

        // Consume on the exact window-end cycle: rate 2 -> 1 without a gap
        do_reset();
        ifc.window_len = 8'd4;
        ifc.enable = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] p;
            p = 8'b0001_0011;
            if (k >= 4) chk("ex_valid_held", int'(ifc.rate_valid), 1);
            if (k == 7) begin
                q.push_back(2);
                q.push_back(1);
                ifc.rate_ready = 1'b1;
            end
            ifc.spike = p[k];
            ifc.enable = (k != 7);
            step();
        end
        ifc.spike = 1'b0;
        chk("ex_valid", int'(ifc.rate_valid), 1);
        chk("ex_rate", int'(ifc.rate), 1);
        chk("ex_dropped", int'(ifc.dropped), 0);
        wait_drain();
        step();
        chk("ex_valid_clear", int'(ifc.rate_valid), 0);

        // Abort mid-window, then a fresh window ignoring a mid-window length change
        do_reset();
        ifc.rate_ready = 1'b1;
        ifc.window_len = 8'd10;
        ifc.enable = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            ifc.spike = (k < 4);
            step();
        end
        ifc.spike = 1'b1;
        ifc.enable = 1'b0;
        step();
        ifc.spike = 1'b0;
        chk("abort_busy", int'(ifc.busy), 0);
        repeat (12) step();
        chk("abort_valid", int'(ifc.rate_valid), 0);
        chk("abort_busy_later", int'(ifc.busy), 0);
        ifc.window_len = 8'd4;
        ifc.enable = 1'b1;
        q.push_back(1);
        step();
        ifc.window_len = 8'd20;
        for (int k = 0; k < 4; k++) begin
            ifc.spike = (k == 0);
            ifc.enable = (k != 3);
            step();
        end
        ifc.spike = 1'b0;
        chk("fresh_valid", int'(ifc.rate_valid), 1);
        wait_drain();
        step();

`ifdef SPIKE_DECODER_ISI_EN
        do_reset();
        chk("isi_reset", int'(ifc.isi), 0);
        ifc.window_len = 8'd0;
        ifc.enable = 1'b1;
        step();
        for (int k = 0; k < 308; k++) begin
            ifc.spike = (k == 2 || k == 7 || k == 307);
            step();
            if (k == 2)   chk("isi_first", int'(ifc.isi), 0);
            if (k == 7)   chk("isi_5", int'(ifc.isi), 5);
            if (k == 307) chk("isi_sat", int'(ifc.isi), 255);
        end
        ifc.spike = 1'b0;
        ifc.enable = 1'b0;
        step();
`endif

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
